hamming_pair_decoder: RTL and testbench
=======================================

Name: hamming_pair_decoder

Overview:
- Receiving end of the even-parity Hamming(7,4) code produced by the team's `binary_2_hamming_pair` encoder.
- Accepts 7-bit codewords on a valid/ready stream and computes the 3-bit syndrome.
- Corrects any single-bit error and emits the recovered 4-bit nibble on a valid/ready output stream through a 2-stage pipeline.
- Keeps a saturating count of corrected words for link-quality monitoring. Sits between the channel/deserialiser and the BCD/display logic.

Parameters:
- CNT_W, 8, width of the corrected-word counter (saturating).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- s_valid  input  1  upstream codeword valid.
- s_data  input  7  codeword; bit H[k-1] is Hamming position k (1..7).
- s_ready  output  1  decoder can accept s_data this cycle.
- m_valid  output  1  decoded nibble valid.
- m_data  output  4  corrected data nibble.
- m_err  output  1  1 = a single-bit error was corrected in this word.
- m_syn  output  3  syndrome of this word ({c4,c2,c1}); 0 = clean.
- m_ready  input  1  downstream accepts m_data.
- cnt_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  number of accepted words with a nonzero syndrome.

Behaviour:
- Code layout:
  - Parity bits sit at positions 1, 2 and 4.
  - Data bits: D[0]=pos3, D[1]=pos5, D[2]=pos6, D[3]=pos7.
  - p1 covers positions {1,3,5,7}; p2 covers {2,3,6,7}; p4 covers {4,5,6,7}; all parity is even.
- Syndrome: c1 = XOR of positions {1,3,5,7}, c2 = XOR of {2,3,6,7}, c4 = XOR of {4,5,6,7}.
  - A nonzero syndrome value is the position to invert.
  - Parity-position errors (syndrome 1, 2 or 4) leave the data unchanged but still set m_err.
  - Double errors are not detected: they produce a miscorrection, and that is the specified behaviour.
- Pipeline:
  - Stage 1 (v1) registers the codeword and its syndrome.
  - Stage 2 (v2) registers the corrected nibble, m_err and m_syn.
  - m_valid = v2.
  - Latency is 2 cycles from the s_valid&&s_ready edge to m_valid, assuming no stall.
- Flow control:
  - adv2 = !v2 || m_ready.
  - adv1 = !v1 || adv2.
  - s_ready = adv1 (combinational, no registered skid).
  - Full throughput is 1 word/cycle.
  - A stage holds its data unchanged while it is not advancing.
  - A transfer occurs only when valid && ready on the same edge.
  - While m_valid=1 && m_ready=0, m_data, m_err and m_syn must stay stable.
- Counter:
  - err_cnt increments on an s_valid&&s_ready cycle whose syndrome != 0.
  - It saturates at 2^CNT_W-1 with no wrap.
  - If cnt_clr and an increment coincide, clear wins and err_cnt = 0 on the next cycle.
- Reset (reset=0 on an edge):
  - v1, v2, m_valid, m_data, m_err, m_syn and err_cnt all go to 0.
  - s_ready is 1 in the first cycle after reset.
  - Reset mid-stream discards in-flight words with no output.
  - Inputs are ignored while reset=0.
- When v1=v2=0 the output registers keep their last value; only m_valid is meaningful.

Decomposition:
- Shared package hamming_pkg holds:
  - position constants (P1=1, P2=2, P4=4, D0_POS=3, D1_POS=5, D2_POS=6, D3_POS=7);
  - the parity-coverage masks (7'b1010101, 7'b1100110, 7'b1111000);
  - a syndrome function.
- The encoder should be migrated to the same package.
- One natural sub-module: hamming_syndrome (combinational, 7-bit codeword in, 3-bit syndrome out). It is used by stage 1 and reusable by the encoder's self-check.

Test Plan:
- Clean word: s_data=7'b1010101 (D=4'b1011), m_ready=1 -> 2 cycles later m_data=4'b1011, m_err=0, m_syn=3'd0; err_cnt=0.
- Data-bit error: s_data=7'b1000101 (pos5 flipped) -> m_data=4'b1011, m_err=1, m_syn=3'd5; err_cnt=1.
- Parity-bit error: s_data=7'b1111110 (pos1 flipped from all-ones, D=4'b1111) -> m_data=4'b1111, m_err=1, m_syn=3'd1.
- Backpressure:
  - Stimulus: stream the 16 encoded nibbles 0..15 back-to-back while m_ready is held 0 for 5 cycles.
  - Response: s_ready=0 once v1=v2=1; the held m_data is stable; after release all 16 nibbles arrive in order with no loss or duplication.
- Counter limits: CNT_W=2, feed 5 erroneous words -> err_cnt=3 (saturated); assert cnt_clr on the same cycle as a 6th erroneous word -> err_cnt=0.
- Reset mid-operation: pull reset=0 with v1=v2=1 -> next cycle m_valid=0, err_cnt=0, s_ready=1; no stale word emitted after reset=1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the even-parity Hamming(7,4) code: bit positions,
// parity coverage masks and helpers used by both encoder and decoder.
package hamming_pkg;

    localparam int P1     = 1;
    localparam int P2     = 2;
    localparam int P4     = 4;
    localparam int D0_POS = 3;
    localparam int D1_POS = 5;
    localparam int D2_POS = 6;
    localparam int D3_POS = 7;

    // Bit k-1 of a codeword holds Hamming position k.
    localparam logic [6:0] MASK_P1 = 7'b1010101;
    localparam logic [6:0] MASK_P2 = 7'b1100110;
    localparam logic [6:0] MASK_P4 = 7'b1111000;

    typedef struct packed {
        logic [6:0] cw;
        logic [2:0] syn;
    } stage1_t;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } stage2_t;

    function automatic logic [2:0] calc_syndrome(input logic [6:0] cw);
        return {^(cw & MASK_P4), ^(cw & MASK_P2), ^(cw & MASK_P1)};
    endfunction

    function automatic logic [3:0] extract_data(input logic [6:0] cw);
        return {cw[D3_POS-1], cw[D2_POS-1], cw[D1_POS-1], cw[D0_POS-1]};
    endfunction

    // A nonzero syndrome names the position to invert; double errors miscorrect.
    function automatic logic [6:0] correct_word(input logic [6:0] cw, input logic [2:0] syn);
        logic [6:0] flip;
        flip = (syn != 3'd0) ? (7'b0000001 << (syn - 3'd1)) : 7'd0;
        return cw ^ flip;
    endfunction

    function automatic logic [6:0] encode_nibble(input logic [3:0] d);
        logic [6:0] cw;
        cw            = 7'd0;
        cw[D0_POS-1]  = d[0];
        cw[D1_POS-1]  = d[1];
        cw[D2_POS-1]  = d[2];
        cw[D3_POS-1]  = d[3];
        cw[P1-1]      = ^(cw & MASK_P1);
        cw[P2-1]      = ^(cw & MASK_P2);
        cw[P4-1]      = ^(cw & MASK_P4);
        return cw;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator: 7-bit codeword in, {c4,c2,c1} out.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [6:0] cw,
    output logic [2:0] syn
);

    assign syn = calc_syndrome(cw);

endmodule

// File: rtl/hamming_pair_decoder.sv
// Two-stage Hamming(7,4) decoder with valid/ready flow control and a
// saturating count of words that needed correction.
module hamming_pair_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic [6:0]       s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [3:0]       m_data,
    output logic             m_err,
    output logic [2:0]       m_syn,
    input  logic             m_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    stage1_t          s1_q, s1_d;
    stage2_t          s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv1, adv2, in_fire;
    logic [2:0]       in_syn;

    hamming_syndrome u_syndrome (
        .cw  (s_data),
        .syn (in_syn)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        v1_d  = v1_q;
        v2_d  = v2_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        cnt_d = cnt_q;

        adv2    = !v2_q || m_ready;
        adv1    = !v1_q || adv2;
        in_fire = s_valid && adv1;

        if (adv1) begin
            v1_d = s_valid;
            if (in_fire) begin
                s1_d.cw  = s_data;
                s1_d.syn = in_syn;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d.data = extract_data(correct_word(s1_q.cw, s1_q.syn));
                s2_d.err  = |s1_q.syn;
                s2_d.syn  = s1_q.syn;
            end
        end

        // Clear has priority over a coincident increment.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_fire && (in_syn != 3'd0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignment; the reset is synchronous and
    // also clears the payload registers so outputs are defined straight after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            cnt_q <= cnt_d;
        end
    end

    assign s_ready = adv1;
    assign m_valid = v2_q;
    assign m_data  = s2_q.data;
    assign m_err   = s2_q.err;
    assign m_syn   = s2_q.syn;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_hamming_pair_decoder.sv
// Randomized and directed bench for hamming_pair_decoder against a
// position-XOR reference model of the Hamming(7,4) code.
module tb_hamming_pair_decoder;

    typedef struct packed {
        logic [3:0] d;
        logic       e;
        logic [2:0] s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, s_valid, m_ready, cnt_clr;
    logic [6:0] s_data;
    logic       s_ready, m_valid, m_err;
    logic [3:0] m_data;
    logic [2:0] m_syn;
    logic [7:0] err_cnt;
    logic       s_ready_b, m_valid_b, m_err_b;
    logic [3:0] m_data_b;
    logic [2:0] m_syn_b;
    logic [1:0] err_cnt_b;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];
    int   m_cnt = 0;
    int   m_cnt_b = 0;

    logic       obs_in_fire, obs_out_fire, obs_s_ready, obs_m_valid, obs_err;
    logic [3:0] obs_data;
    logic [2:0] obs_syn;

    hamming_pair_decoder #(.CNT_W(8)) dut (
        .clk     (clk),     .reset   (reset),
        .s_valid (s_valid), .s_data  (s_data),  .s_ready (s_ready),
        .m_valid (m_valid), .m_data  (m_data),  .m_err   (m_err),
        .m_syn   (m_syn),   .m_ready (m_ready),
        .cnt_clr (cnt_clr), .err_cnt (err_cnt)
    );

    hamming_pair_decoder #(.CNT_W(2)) dut_b (
        .clk     (clk),       .reset   (reset),
        .s_valid (s_valid),   .s_data  (s_data),   .s_ready (s_ready_b),
        .m_valid (m_valid_b), .m_data  (m_data_b), .m_err   (m_err_b),
        .m_syn   (m_syn_b),   .m_ready (m_ready),
        .cnt_clr (cnt_clr),   .err_cnt (err_cnt_b)
    );

    always #5 clk = ~clk;

    // Syndrome of a Hamming code is the XOR of the positions of all set bits.
    function automatic logic [2:0] ref_syn(input logic [6:0] cw);
        int x = 0;
        for (int k = 1; k <= 7; k++) if (cw[k-1]) x = x ^ k;
        return x[2:0];
    endfunction

    function automatic exp_t ref_decode(input logic [6:0] cw);
        exp_t       r;
        logic [6:0] fixed = cw;
        int         syn = int'(ref_syn(cw));
        if (syn != 0) fixed[syn-1] = ~fixed[syn-1];
        r.d = {fixed[6], fixed[5], fixed[4], fixed[2]};
        r.e = (syn != 0);
        r.s = syn[2:0];
        return r;
    endfunction

    function automatic logic [6:0] ref_encode(input logic [3:0] nib);
        int         pos[4] = '{3, 5, 6, 7};
        int         x = 0;
        logic [6:0] cw = 7'd0;
        for (int i = 0; i < 4; i++) begin
            if (nib[i]) begin
                cw[pos[i]-1] = 1'b1;
                x = x ^ pos[i];
            end
        end
        cw[0] = x[0];
        cw[1] = x[1];
        cw[3] = x[2];
        return cw;
    endfunction

    function automatic logic [6:0] one_error_word();
        logic [6:0] cw = ref_encode(4'($urandom_range(0, 15)));
        int         p  = $urandom_range(0, 6);
        cw[p] = ~cw[p];
        return cw;
    endfunction

    // Observe one cycle at the falling edge, update the model, then advance.
    task automatic step();
        @(negedge clk);
        obs_s_ready  = s_ready;
        obs_m_valid  = m_valid;
        obs_data     = m_data;
        obs_err      = m_err;
        obs_syn      = m_syn;
        obs_in_fire  = reset && s_valid && s_ready;
        obs_out_fire = reset && m_valid && m_ready;
        if (!reset) begin
            exp_q.delete();
            m_cnt   = 0;
            m_cnt_b = 0;
        end else begin
            if (obs_in_fire) exp_q.push_back(ref_decode(s_data));
            if (cnt_clr) begin
                m_cnt   = 0;
                m_cnt_b = 0;
            end else if (obs_in_fire && ref_syn(s_data) != 3'd0) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_b < 3) m_cnt_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b1; s_data = 7'b0000001; m_ready = 1'b1; cnt_clr = 1'b0;
        step();
        step();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b want=1", s_ready); end
        total++; if ({m_data, m_err, m_syn} !== 8'd0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%0d want=0/0/0", m_data, m_err, m_syn); end
        total++; if (err_cnt !== 8'd0 || err_cnt_b !== 2'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d/%0d want=0/0", err_cnt, err_cnt_b); end
        reset = 1'b1; s_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [6:0] cw_t [3] = '{7'b1010101, 7'b1000101, 7'b1111110};
        logic [3:0] d_t  [3] = '{4'b1011, 4'b1011, 4'b1111};
        logic       e_t  [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] s_t  [3] = '{3'd0, 3'd5, 3'd1};
        int         c_t  [3] = '{0, 1, 2};
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = cw_t[i];
            step();
            s_valid = 1'b0;
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_latency1 got m_valid=%0b want=0", i, m_valid); end
            step();
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency2 got m_valid=%0b want=1", i, m_valid); end
            total++; if ({m_data, m_err, m_syn} !== {d_t[i], e_t[i], s_t[i]}) begin
                bad++; $display("FAIL dir%0d_word got=%b/%b/%0d want=%b/%b/%0d", i, m_data, m_err, m_syn, d_t[i], e_t[i], s_t[i]);
            end
            total++; if (int'(err_cnt) !== c_t[i]) begin bad++; $display("FAIL dir%0d_err_cnt got=%0d want=%0d", i, err_cnt, c_t[i]); end
            step();
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int         idx = 0;
        int         got = 0;
        logic [7:0] held = 8'd0;
        exp_t       e;
        m_ready = 1'b0; s_valid = 1'b1; s_data = ref_encode(4'd0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            step();
            if (obs_in_fire) begin
                idx++;
                s_data = ref_encode(4'(idx));
            end
            if (cyc >= 2) begin
                total++; if (obs_s_ready !== 1'b0 || obs_m_valid !== 1'b1) begin
                    bad++; $display("FAIL bp_stall%0d got s_ready=%0b m_valid=%0b want 0/1", cyc, obs_s_ready, obs_m_valid);
                end
                if (cyc == 2) held = {obs_data, obs_err, obs_syn};
                else begin
                    total++; if ({obs_data, obs_err, obs_syn} !== held) begin
                        bad++; $display("FAIL bp_hold%0d got=%h want=%h", cyc, {obs_data, obs_err, obs_syn}, held);
                    end
                end
            end
        end
        total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", idx); end
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            s_valid = (idx < 16);
            step();
            if (obs_in_fire) begin
                idx++;
                if (idx < 16) s_data = ref_encode(4'(idx));
            end
            if (obs_out_fire) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL bp_extra got=%h want=none", obs_data);
                end else begin
                    e = exp_q.pop_front();
                    total++; if (obs_data !== e.d || obs_data !== 4'(got) || obs_err !== e.e || obs_syn !== e.s) begin
                        bad++; $display("FAIL bp_word%0d got=%h/%b/%0d want=%h/%b/%0d", got, obs_data, obs_err, obs_syn, 4'(got), e.e, e.s);
                    end
                end
                got++;
            end
        end
        s_valid = 1'b0;
        total++; if (got !== 16 || exp_q.size() != 0) begin bad++; $display("FAIL bp_count got=%0d left=%0d want=16/0", got, exp_q.size()); end
    endtask

    task automatic test_random();
        logic       prev_stall = 1'b0;
        logic [7:0] held = 8'd0;
        logic [6:0] cw;
        exp_t       e;
        for (int cyc = 0; cyc < 300; cyc++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            cw = ref_encode(4'($urandom_range(0, 15)));
            for (int f = $urandom_range(0, 2); f > 0; f--) begin
                int p = $urandom_range(0, 6);
                cw[p] = ~cw[p];
            end
            s_data = cw;
            step();
            if (prev_stall) begin
                total++; if ({obs_data, obs_err, obs_syn} !== held || obs_m_valid !== 1'b1) begin
                    bad++; $display("FAIL rnd_hold cyc=%0d got=%h want=%h", cyc, {obs_data, obs_err, obs_syn}, held);
                end
            end
            prev_stall = obs_m_valid && !m_ready;
            held = {obs_data, obs_err, obs_syn};
            if (obs_out_fire) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_extra cyc=%0d got=%h want=none", cyc, obs_data);
                end else begin
                    e = exp_q.pop_front();
                    total++; if ({obs_data, obs_err, obs_syn} !== e) begin
                        bad++; $display("FAIL rnd_word cyc=%0d got=%h/%b/%0d want=%h/%b/%0d", cyc, obs_data, obs_err, obs_syn, e.d, e.e, e.s);
                    end
                end
            end
            total++; if (int'(err_cnt) !== m_cnt || int'(err_cnt_b) !== m_cnt_b) begin
                bad++; $display("FAIL rnd_err_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, err_cnt, err_cnt_b, m_cnt, m_cnt_b);
            end
        end
        s_valid = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0;
        for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
            step();
            if (obs_out_fire) begin
                e = exp_q.pop_front();
                total++; if ({obs_data, obs_err, obs_syn} !== e) begin
                    bad++; $display("FAIL rnd_drain got=%h/%b/%0d want=%h/%b/%0d", obs_data, obs_err, obs_syn, e.d, e.e, e.s);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_counter_limits();
        m_ready = 1'b1; s_valid = 1'b0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++; if (err_cnt !== 8'd0 || err_cnt_b !== 2'd0) begin bad++; $display("FAIL cnt_clear got=%0d/%0d want=0/0", err_cnt, err_cnt_b); end
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = one_error_word();
            step();
        end
        total++; if (err_cnt_b !== 2'd3) begin bad++; $display("FAIL cnt_saturate got=%0d want=3", err_cnt_b); end
        total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL cnt_wide got=%0d want=5", err_cnt); end
        s_data = one_error_word(); cnt_clr = 1'b1;
        step();
        total++; if (err_cnt !== 8'd0 || err_cnt_b !== 2'd0) begin bad++; $display("FAIL cnt_clr_wins got=%0d/%0d want=0/0", err_cnt, err_cnt_b); end
        s_valid = 1'b0; cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data = one_error_word();
            step();
        end
        total++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL mid_full got m_valid=%0b s_ready=%0b want 1/0", m_valid, s_ready); end
        reset = 1'b0; s_data = one_error_word();
        step();
        total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got m_valid=%0b s_ready=%0b want 0/1", m_valid, s_ready); end
        total++; if (err_cnt !== 8'd0 || err_cnt_b !== 2'd0) begin bad++; $display("FAIL mid_err_cnt got=%0d/%0d want=0/0", err_cnt, err_cnt_b); end
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (obs_m_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got m_valid=1 want=0", i); end
        end
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = 7'd0; m_ready = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_counter_limits();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
